weight_stream_fifo: RTL and testbench
=====================================

Name: weight_stream_fifo

Overview:
Parametrised successor to the team's weight FIFO. It buffers full weight tiles (NUM_PE_ROWS x MATRIX_SIZE words) between the weight loader and the systolic PE array, using valid/ready handshakes on both sides.
- Simultaneous push/pop is correct.
- Output mode is selectable: first-word-fall-through (FWFT) or registered-read.
- Almost-full/almost-empty flags are programmable.
- A mark/rewind replay mechanism lets one loaded tile sequence be re-streamed for weight reuse across activation batches without reloading.

Parameters:
- WEIGHT_BW, 8, bits per weight
- NUM_PE_ROWS, 8, PE rows per tile
- MATRIX_SIZE, 8, columns per tile
- FIFO_DEPTH, 8, entries; power of two, >=2
- AFULL_THRESH, FIFO_DEPTH-2, almost_full asserted when held >= value
- AEMPTY_THRESH, 1, almost_empty asserted when count <= value
- FWFT, 1, 1 = fall-through output, 0 = registered read with 1-cycle latency
- Derived: W = WEIGHT_BW*NUM_PE_ROWS*MATRIX_SIZE; CW = $clog2(FIFO_DEPTH+1)

Ports:
- clk  in  1  clock
- rstn  in  1  reset: rstn, synchronous, active-low; clock clk
- in_valid  in  1  write data valid
- in_ready  out  1  space available (= !full)
- in_data  in  W  weight tile
- out_valid  out  1  out_data valid
- out_ready  in  1  FWFT=1: consumer accepts; FWFT=0: read request
- out_data  out  W  weight tile
- replay_mark  in  1  pin current head as replay start
- replay_rewind  in  1  restore read pointer to mark
- replay_release  in  1  drop mark, free retained entries
- count  out  CW  readable entries (includes output stage)
- held  out  CW  occupied slots (count plus retained-but-read entries)
- almost_full  out  1
- almost_empty  out  1
- retain  out  1  mark active
- err_rewind  out  1  sticky: rewind/mark misuse; cleared only by reset

Behaviour:
- Reset (rstn=0 at posedge): all pointers and counters are 0; out_valid=0, out_data=0, retain=0, err_rewind=0, in_ready=1, almost_empty=1, almost_full=0. Memory contents are not reset. Reset mid-stream discards everything, including the mark.
- Pointers: wr_ptr, rd_ptr, and mark_ptr are each $clog2(FIFO_DEPTH)+1 bits, so wrap-around is distinguished by the MSB.
  - count = wr_ptr - rd_ptr
  - held = retain ? wr_ptr - mark_ptr : count
  - full = (held == FIFO_DEPTH)
- Push: accepted when in_valid && in_ready. Memory is written at wr_ptr, and wr_ptr increments.
  - in_ready depends only on state. A push into a full FIFO is blocked even if a pop occurs in the same cycle.
- Pop, FWFT=1: a 1-entry output stage is prefetched from memory.
  - out_valid=1 whenever the stage holds data.
  - A pop happens when out_valid && out_ready.
  - A write to an empty FIFO at cycle t gives out_valid=1 at t+2.
  - Back-to-back pops sustain 1 entry per cycle.
- Pop, FWFT=0: an out_ready request with count>0 at cycle t gives out_valid=1 for exactly one cycle at t+1, with data from the old rd_ptr.
  - A request with count==0 is ignored and out_valid stays 0.
- Simultaneous push and pop: count is unchanged. held is unchanged unless retain=1, in which case held increments.
- Replay:
  - replay_mark: mark_ptr <= index of the current head (the output-stage entry if valid); retain <= 1.
  - Retained entries are not freed by pops, so full is computed from held.
  - replay_rewind while retain=1: rd_ptr <= mark_ptr and the output stage is flushed.
    - out_valid=0 the next cycle.
    - FWFT=1: the mark entry is re-presented 2 cycles after rewind.
    - A push in the rewind cycle is still accepted.
  - replay_rewind while retain=0: ignored; err_rewind <= 1.
  - replay_mark while retain=1: re-marks at the current head; entries before the new mark are freed.
  - replay_release: retain <= 0; held drops to count in the next cycle.
  - Priority when asserted together: release > rewind > mark. A pop in the same cycle as a rewind is discarded.
- Flags are registered and reflect post-update state, valid the cycle after the event.

Decomposition:
- Package weight_fifo_pkg: localparam function for W; pointer-width helper; FWFT mode constants.
- Sub-module weight_fifo_ram: simple dual-port synchronous RAM, (* ram_style="block" *), one write port and one read port with registered output.
- Pointer, flag, replay, and output-stage logic live in weight_stream_fifo.

Test Plan:
1. FWFT=1, DEPTH=8: push 0x01..0x08 with out_ready=0 -> in_ready=0 after the 8th push, held=8, almost_full=1; then out_ready=1 -> 0x01..0x08 in order, 1 per cycle, almost_empty=1 at count<=1.
2. FWFT=1: continuous push and pop for 20 cycles with data=cycle index -> count stays constant, no gaps, pointers wrap twice, data in order.
3. FWFT=0: out_ready pulse on an empty FIFO -> no out_valid; push 0xA5, request at t -> out_valid=1 with 0xA5 only at t+1.
4. Replay: push 4 tiles, mark, pop all 4, rewind -> out_valid=0 one cycle, then 4 tiles re-emitted (out_valid at rewind+2); held=4 throughout; release -> held=0.
5. Retention full: DEPTH=4, mark, push 4, pop 2 -> in_ready stays 0 (held=4); release -> in_ready=1 next cycle.
6. Rewind without mark -> err_rewind=1, stream unaffected; assert rstn=0 mid-stream -> all outputs at reset values next cycle, err_rewind=0.

Source files
------------

// File: rtl/weight_stream_fifo_pkg.sv
// Shared definitions for the weight tile stream FIFO: tile width, pointer width,
// output-mode constants.
package weight_fifo_pkg;

  localparam bit FWFT_MODE = 1'b1;
  localparam bit REG_MODE  = 1'b0;

  function automatic int tile_width(input int bw, input int rows, input int cols);
    return bw * rows * cols;
  endfunction

  // One extra MSB so a full ring is distinguishable from an empty one.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/weight_stream_fifo_if.sv
// Loader-side and PE-side valid/ready handshake bundle for the weight tile FIFO.
interface weight_stream_fifo_if import weight_fifo_pkg::*; #(
  parameter int W = tile_width(8, 8, 8)
) ();
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/weight_stream_fifo_ram.sv
// Simple dual-port synchronous RAM with registered read data; holds one PE row
// slice of every buffered tile.
module weight_fifo_ram #(
  parameter int DW = 64,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  (* ram_style = "block" *) logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/weight_stream_fifo.sv
// Weight tile FIFO between loader and PE array: FWFT or registered read,
// programmable almost flags, mark/rewind replay of retained tiles.
module weight_stream_fifo import weight_fifo_pkg::*; #(
  parameter int WEIGHT_BW     = 8,
  parameter int NUM_PE_ROWS   = 8,
  parameter int MATRIX_SIZE   = 8,
  parameter int FIFO_DEPTH    = 8,
  parameter int AFULL_THRESH  = FIFO_DEPTH - 2,
  parameter int AEMPTY_THRESH = 1,
  parameter bit FWFT          = FWFT_MODE,
  localparam int CW           = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rstn,
  weight_stream_fifo_if.slave  bus,
  input  logic                 replay_mark,
  input  logic                 replay_rewind,
  input  logic                 replay_release,
  output logic [CW-1:0]        count,
  output logic [CW-1:0]        held,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 retain,
  output logic                 err_rewind
);
  localparam int PW    = ptr_width(FIFO_DEPTH);
  localparam int AW    = PW - 1;
  localparam int ROW_W = WEIGHT_BW * MATRIX_SIZE;

  logic [PW-1:0] wr_ptr, rd_ptr, mark_ptr;
  logic [PW-1:0] wr_ptr_n, rd_ptr_n, mark_ptr_n;
  logic [PW-1:0] cnt_p, held_p, cnt_n, held_n;
  logic          retain_n, stage_vld, stage_vld_n;
  logic          full, push, pop, rd_en;
  logic          do_rel, do_rew, do_mark;
  logic [AW-1:0] rd_addr;

  logic [NUM_PE_ROWS-1:0][ROW_W-1:0] wr_rows, rd_rows;

  assign cnt_p  = wr_ptr - rd_ptr;
  assign held_p = retain ? (wr_ptr - mark_ptr) : cnt_p;
  assign full   = (held_p == PW'(FIFO_DEPTH));
  assign count  = CW'(cnt_p);
  assign held   = CW'(held_p);

  assign bus.in_ready = !full;
  assign push         = bus.in_valid && !full;

  // release beats rewind beats mark; a rewind without a mark does nothing.
  assign do_rel  = replay_release;
  assign do_rew  = replay_rewind && retain && !replay_release;
  assign do_mark = replay_mark && !replay_release && !do_rew;

  always_comb begin
    pop         = 1'b0;
    rd_en       = 1'b0;
    rd_addr     = rd_ptr[AW-1:0];
    stage_vld_n = stage_vld;
    if (FWFT == FWFT_MODE) begin
      // The RAM read register is the output stage; rd_ptr names the staged head,
      // so refills fetch the entry just behind it.
      pop     = stage_vld && bus.out_ready && !do_rew;
      rd_en   = !do_rew && (!stage_vld || pop) &&
                (stage_vld ? (cnt_p > PW'(1)) : (cnt_p != '0));
      rd_addr = AW'(rd_ptr + PW'(stage_vld));
      if (do_rew)     stage_vld_n = 1'b0;
      else if (rd_en) stage_vld_n = 1'b1;
      else if (pop)   stage_vld_n = 1'b0;
    end else begin
      pop         = bus.out_ready && (cnt_p != '0) && !do_rew;
      rd_en       = pop;
      stage_vld_n = pop;
    end
  end

  assign wr_ptr_n   = wr_ptr + PW'(push);
  assign rd_ptr_n   = do_rew ? mark_ptr : (rd_ptr + PW'(pop));
  assign mark_ptr_n = do_mark ? rd_ptr : mark_ptr;
  assign retain_n   = do_rel ? 1'b0 : (do_mark ? 1'b1 : retain);
  assign cnt_n      = wr_ptr_n - rd_ptr_n;
  assign held_n     = retain_n ? (wr_ptr_n - mark_ptr_n) : cnt_n;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      mark_ptr     <= '0;
      retain       <= 1'b0;
      stage_vld    <= 1'b0;
      err_rewind   <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      wr_ptr       <= wr_ptr_n;
      rd_ptr       <= rd_ptr_n;
      mark_ptr     <= mark_ptr_n;
      retain       <= retain_n;
      stage_vld    <= stage_vld_n;
      err_rewind   <= err_rewind | (replay_rewind & ~retain);
      almost_full  <= int'(held_n) >= AFULL_THRESH;
      almost_empty <= int'(cnt_n) <= AEMPTY_THRESH;
    end
  end

  assign wr_rows = bus.in_data;

  for (genvar r = 0; r < NUM_PE_ROWS; r++) begin : g_row
    weight_fifo_ram #(.DW(ROW_W), .AW(AW)) u_ram (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr[AW-1:0]),
      .wdata (wr_rows[r]),
      .re    (rd_en),
      .raddr (rd_addr),
      .rdata (rd_rows[r])
    );
  end

  // RAM read register is not reset, so hide it while nothing is staged.
  assign bus.out_valid = stage_vld;
  assign bus.out_data  = stage_vld ? rd_rows : '0;
endmodule

// File: tb/tb_weight_stream_fifo.sv
// Bench for weight_stream_fifo: three configurations driven in turn, checked each
// cycle against a queue model of held tiles plus literal spot checks.
module tb_weight_stream_fifo;
  localparam int W = 512;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic replay_mark = 1'b0, replay_rewind = 1'b0, replay_release = 1'b0;

  always #5 clk = ~clk;

  weight_stream_fifo_if #(.W(W)) bus8 ();
  weight_stream_fifo_if #(.W(W)) bus4 ();
  weight_stream_fifo_if #(.W(W)) bus0 ();

  assign bus8.in_valid = in_valid;  assign bus8.in_data = in_data;  assign bus8.out_ready = out_ready;
  assign bus4.in_valid = in_valid;  assign bus4.in_data = in_data;  assign bus4.out_ready = out_ready;
  assign bus0.in_valid = in_valid;  assign bus0.in_data = in_data;  assign bus0.out_ready = out_ready;

  logic [3:0] cnt8, held8, cnt0, held0;
  logic [2:0] cnt4, held4;
  logic af8, ae8, rt8, er8, af4, ae4, rt4, er4, af0, ae0, rt0, er0;

  weight_stream_fifo #(.FIFO_DEPTH(8), .FWFT(1'b1)) dut8 (
    .clk(clk), .rstn(rstn), .bus(bus8), .replay_mark(replay_mark), .replay_rewind(replay_rewind),
    .replay_release(replay_release), .count(cnt8), .held(held8), .almost_full(af8),
    .almost_empty(ae8), .retain(rt8), .err_rewind(er8));

  weight_stream_fifo #(.FIFO_DEPTH(4), .AFULL_THRESH(2), .FWFT(1'b1)) dut4 (
    .clk(clk), .rstn(rstn), .bus(bus4), .replay_mark(replay_mark), .replay_rewind(replay_rewind),
    .replay_release(replay_release), .count(cnt4), .held(held4), .almost_full(af4),
    .almost_empty(ae4), .retain(rt4), .err_rewind(er4));

  weight_stream_fifo #(.FIFO_DEPTH(8), .FWFT(1'b0)) dut0 (
    .clk(clk), .rstn(rstn), .bus(bus0), .replay_mark(replay_mark), .replay_rewind(replay_rewind),
    .replay_release(replay_release), .count(cnt0), .held(held0), .almost_full(af0),
    .almost_empty(ae0), .retain(rt0), .err_rewind(er0));

  // Outputs of the configuration under test.
  int sel = 0;
  logic o_v, o_r, o_af, o_ae, o_rt, o_er;
  logic [W-1:0] o_d;
  int o_c, o_h;
  always_comb begin
    o_v = bus8.out_valid; o_d = bus8.out_data; o_r = bus8.in_ready;
    o_c = int'(cnt8); o_h = int'(held8); o_af = af8; o_ae = ae8; o_rt = rt8; o_er = er8;
    case (sel)
      1: begin
        o_v = bus4.out_valid; o_d = bus4.out_data; o_r = bus4.in_ready;
        o_c = int'(cnt4); o_h = int'(held4); o_af = af4; o_ae = ae4; o_rt = rt4; o_er = er4;
      end
      2: begin
        o_v = bus0.out_valid; o_d = bus0.out_data; o_r = bus0.in_ready;
        o_c = int'(cnt0); o_h = int'(held0); o_af = af0; o_ae = ae0; o_rt = rt0; o_er = er0;
      end
      default: ;
    endcase
  end

  int checks = 0, errors = 0;
  bit checking = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s sel=%0d got=%0d want=%0d t=%0t", nm, sel, act, exp, $time);
    end
  endtask

  task automatic chk_d(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s sel=%0d got=%0h want=%0h", nm, sel, act, exp);
    end
  endtask

  // Model: mq holds every occupied tile oldest first; hd is how many of them have
  // already been read but are retained behind the mark.
  int m_depth = 8, m_af = 6;
  bit m_fwft = 1'b1;
  logic [W-1:0] mq[$];
  int hd = 0;
  bit m_ret = 1'b0, m_err = 1'b0, m_ov = 1'b0;
  logic [W-1:0] m_od = '0;

  always @(posedge clk) begin
    int cnt_pre, ndrop;
    bit push, pop, erw;
    logic [W-1:0] head_pre;
    if (!rstn) begin
      mq.delete(); hd = 0; m_ret = 0; m_err = 0; m_ov = 0; m_od = '0;
    end else begin
      cnt_pre  = mq.size() - hd;
      head_pre = (cnt_pre > 0) ? mq[hd] : '0;
      push     = in_valid && (mq.size() < m_depth);
      erw      = replay_rewind && m_ret && !replay_release;
      if (replay_rewind && !m_ret) m_err = 1;
      if (m_fwft) pop = m_ov && out_ready && !erw;
      else        pop = out_ready && (cnt_pre > 0) && !erw;
      if (replay_release) begin
        if (pop) hd++;
        ndrop = hd;
        for (int k = 0; k < ndrop; k++) void'(mq.pop_front());
        hd = 0; m_ret = 0;
      end else if (erw) begin
        hd = 0;
      end else begin
        if (replay_mark) begin
          ndrop = hd;
          for (int k = 0; k < ndrop; k++) void'(mq.pop_front());
          hd = 0; m_ret = 1;
        end
        if (pop) begin
          if (m_ret) hd++;
          else void'(mq.pop_front());
        end
      end
      if (push) mq.push_back(in_data);
      if (m_fwft) begin
        m_ov = !erw && (cnt_pre - int'(pop) > 0);
        m_od = m_ov ? mq[hd] : '0;
      end else begin
        m_ov = pop;
        m_od = head_pre;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("out_valid", int'(o_v), int'(m_ov));
      if (m_ov) chk_d("out_data", o_d, m_od);
      chk("in_ready", int'(o_r), int'(mq.size() < m_depth));
      chk("count", o_c, mq.size() - hd);
      chk("held", o_h, mq.size());
      chk("almost_full", int'(o_af), int'(mq.size() >= m_af));
      chk("almost_empty", int'(o_ae), int'(mq.size() - hd <= 1));
      chk("retain", int'(o_rt), int'(m_ret));
      chk("err_rewind", int'(o_er), int'(m_err));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    in_valid = 0; out_ready = 0; replay_mark = 0; replay_rewind = 0; replay_release = 0;
  endtask

  function automatic logic [W-1:0] rnd_tile();
    logic [W-1:0] t;
    for (int i = 0; i < W / 32; i++) t[i*32 +: 32] = $urandom;
    return t;
  endfunction

  task automatic start_phase(input int s, input int depth, input int af, input bit fwft);
    checking = 0;
    idle_inputs();
    sel = s; m_depth = depth; m_af = af; m_fwft = fwft;
    rstn = 0; tick(); tick();
    rstn = 1;
    checking = 1;
  endtask

  task automatic run_rand(input int n);
    for (int i = 0; i < n; i++) begin
      bit hi;
      hi = ((i / 64) % 2) == 1;
      in_valid       = $urandom_range(0, 99) < (hi ? 85 : 30);
      in_data        = rnd_tile();
      out_ready      = $urandom_range(0, 99) < (hi ? 30 : 80);
      replay_mark    = $urandom_range(0, 49) == 0;
      replay_rewind  = (m_ret && $urandom_range(0, 29) == 0) || ($urandom_range(0, 399) == 0);
      replay_release = $urandom_range(0, 79) == 0;
      tick();
    end
    idle_inputs();
    tick();
  endtask

  logic [W-1:0] tiles [4];

  initial begin
    tick();
    // ---- depth 8, fall-through ----
    start_phase(0, 8, 6, 1'b1);
    chk("rst_out_valid", int'(o_v), 0);
    chk("rst_in_ready", int'(o_r), 1);
    chk("rst_almost_empty", int'(o_ae), 1);

    for (int i = 1; i <= 8; i++) begin
      in_valid = 1; in_data = W'(i); tick();
    end
    in_valid = 0;
    chk("fill_held", o_h, 8);
    chk("fill_in_ready", int'(o_r), 0);
    chk("fill_almost_full", int'(o_af), 1);
    out_ready = 1;
    for (int k = 0; k < 10; k++) begin
      if (k < 8) begin
        chk("drain_valid", int'(o_v), 1);
        chk_d("drain_data", o_d, W'(k + 1));
      end
      tick();
    end
    out_ready = 0;
    chk("drain_count", o_c, 0);
    chk("drain_almost_empty", int'(o_ae), 1);

    in_valid = 1; out_ready = 1;
    for (int i = 0; i < 20; i++) begin
      in_data = W'(i); tick();
    end
    in_valid = 0;
    chk("stream_count", o_c, 2);
    repeat (4) tick();
    out_ready = 0;

    for (int i = 0; i < 4; i++) begin
      tiles[i] = rnd_tile(); in_valid = 1; in_data = tiles[i]; tick();
    end
    in_valid = 0; tick();
    replay_mark = 1; tick(); replay_mark = 0;
    chk("mark_retain", int'(o_rt), 1);
    out_ready = 1; repeat (4) tick(); out_ready = 0;
    chk("popped_count", o_c, 0);
    chk("popped_held", o_h, 4);
    replay_rewind = 1; tick(); replay_rewind = 0;
    chk("rewind_gap", int'(o_v), 0);
    tick();
    chk("rewind_valid", int'(o_v), 1);
    chk_d("rewind_data", o_d, tiles[0]);
    out_ready = 1; repeat (4) tick(); out_ready = 0;
    chk("replay_held", o_h, 4);
    replay_release = 1; tick(); replay_release = 0;
    chk("release_held", o_h, 0);

    in_valid = 1; in_data = rnd_tile(); out_ready = 1; replay_rewind = 1; tick();
    replay_rewind = 0; in_data = rnd_tile(); tick();
    in_valid = 0;
    chk("err_set", int'(o_er), 1);
    tick();
    in_valid = 1; in_data = rnd_tile(); out_ready = 0; tick();
    rstn = 0; tick(); rstn = 1; in_valid = 0;
    chk("midrst_valid", int'(o_v), 0);
    chk_d("midrst_data", o_d, '0);
    chk("midrst_err", int'(o_er), 0);
    chk("midrst_held", o_h, 0);
    chk("midrst_in_ready", int'(o_r), 1);
    run_rand(700);

    // ---- depth 4, retention fills the ring ----
    start_phase(1, 4, 2, 1'b1);
    replay_mark = 1; tick(); replay_mark = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_data = rnd_tile(); tick();
    end
    in_valid = 0;
    out_ready = 1; repeat (2) tick(); out_ready = 0;
    chk("ret_count", o_c, 2);
    chk("ret_in_ready", int'(o_r), 0);
    in_valid = 1; in_data = rnd_tile(); tick(); in_valid = 0;
    chk("ret_blocked_held", o_h, 4);
    replay_release = 1; tick(); replay_release = 0;
    chk("ret_release_ready", int'(o_r), 1);
    chk("ret_release_held", o_h, 2);
    run_rand(400);

    // ---- depth 8, registered read ----
    start_phase(2, 8, 6, 1'b0);
    out_ready = 1; tick(); out_ready = 0;
    chk("reg_empty_req", int'(o_v), 0);
    in_valid = 1; in_data = W'(8'hA5); tick(); in_valid = 0;
    out_ready = 1; tick(); out_ready = 0;
    chk("reg_valid", int'(o_v), 1);
    chk_d("reg_data", o_d, W'(8'hA5));
    tick();
    chk("reg_one_shot", int'(o_v), 0);
    run_rand(500);

    checking = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
